// File: rtl/thermocouple_scanner.sv
// Multi-channel thermocouple front end: round-robins an SPI master over NUM_CH converters and unpacks frames.
// Latency: capture registers update on the edge that ends the one-cycle CAPTURE state; scans repeat every PERIOD_CYCLES idle gap.
// Backpressure: waits on spi_not_busy in each handshake phase, bounded by TIMEOUT_CYCLES, then flags and skips the channel.
module thermocouple_scanner #(
  parameter int NUM_CH         = 4,
  parameter int CH_BITS        = 2,
  parameter int CLK_FREQ       = 800,
  parameter int STARTUP_CYCLES = CLK_FREQ * 3,
  parameter int PERIOD_CYCLES  = CLK_FREQ,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CBITS          = 12,
  parameter int FAULT_FILT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_en,
  input  logic                   spi_not_busy,
  input  logic [31:0]            spi_rx_data,
  output logic                   spi_ena,
  output logic [NUM_CH-1:0]      spi_cs,
  output logic [14*NUM_CH-1:0]   tc_temp_data,
  output logic [12*NUM_CH-1:0]   junction_temp_data,
  output logic [4*NUM_CH-1:0]    fault_bits,
  output logic [NUM_CH-1:0]      timeout_flags,
  output logic                   sample_valid,
  output logic [CH_BITS-1:0]     sample_ch
);

  localparam int FBITS = $clog2(FAULT_FILT + 1);

  localparam logic [CBITS-1:0]   C_START_LAST  = CBITS'(STARTUP_CYCLES - 1);
  localparam logic [CBITS-1:0]   C_PERIOD_LAST = CBITS'(PERIOD_CYCLES - 1);
  localparam logic [CBITS-1:0]   C_TO_LAST     = CBITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CBITS-1:0]   C_ONE         = CBITS'(1);
  localparam logic [CH_BITS-1:0] C_CH_LAST     = CH_BITS'(NUM_CH - 1);
  localparam logic [CH_BITS-1:0] C_CH_ONE      = CH_BITS'(1);
  localparam logic [FBITS-1:0]   C_FILT        = FBITS'(FAULT_FILT);
  localparam logic [FBITS-1:0]   C_FILT_ONE    = FBITS'(1);

  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_IDLE    = 3'd1,
    S_REQ     = 3'd2,
    S_BUSY    = 3'd3,
    S_CAPTURE = 3'd4,
    S_NEXT    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CBITS-1:0]     r_cnt;
  logic [CBITS-1:0]     w_cnt_nxt;
  logic [CH_BITS-1:0]   r_ch;
  logic [CH_BITS-1:0]   w_ch_nxt;
  logic                 w_to_set;

  logic [14*NUM_CH-1:0] r_tc;
  logic [12*NUM_CH-1:0] r_jn;
  logic [4*NUM_CH-1:0]  r_fault;
  logic [NUM_CH-1:0]    r_to;
  logic [FBITS-1:0]     r_filt [NUM_CH];

  // Frame bits 17 and 3 carry no information for this block.
  logic                 w_unused_rx;
  assign w_unused_rx = ^{spi_rx_data[17], spi_rx_data[3]};

  assign tc_temp_data       = r_tc;
  assign junction_temp_data = r_jn;
  assign fault_bits         = r_fault;
  assign timeout_flags      = r_to;

  // State, shared phase counter and channel index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_STARTUP;
      r_cnt   <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  // Next-state logic: startup wait, scan period, bounded SPI handshake, channel stepping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_to_set    = 1'b0;
    case (r_state)
      S_STARTUP: begin
        if (r_cnt == C_START_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_IDLE: begin
        if (!scan_en) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == C_PERIOD_LAST) begin
          w_state_nxt = S_REQ;
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_REQ: begin
        if (!spi_not_busy) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt = S_NEXT;
          w_cnt_nxt   = '0;
          w_to_set    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_BUSY: begin
        if (spi_not_busy) begin
          w_state_nxt = S_CAPTURE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TO_LAST) begin
          w_state_nxt = S_NEXT;
          w_cnt_nxt   = '0;
          w_to_set    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_NEXT;
        w_cnt_nxt   = '0;
      end
      S_NEXT: begin
        w_cnt_nxt = '0;
        if (r_ch == C_CH_LAST) begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
        end else begin
          w_state_nxt = S_REQ;
          w_ch_nxt    = r_ch + C_CH_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_ch_nxt    = '0;
      end
    endcase
  end

  // Outputs decoded from state so reset drops request and chip select at once.
  always_comb begin
    spi_ena      = (r_state == S_REQ);
    sample_valid = (r_state == S_CAPTURE);
    sample_ch    = (r_state == S_CAPTURE) ? r_ch : '0;
    spi_cs       = '0;
    if (r_state == S_REQ || r_state == S_BUSY || r_state == S_CAPTURE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        spi_cs[k] = (r_ch == CH_BITS'(k));
      end
    end
  end

  // Frame unpack, fault debounce with hold-last-good temperatures, and timeout flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tc    <= '0;
      r_jn    <= '0;
      r_fault <= '0;
      r_to    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_filt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_state == S_CAPTURE && r_ch == CH_BITS'(k)) begin
          r_fault[4*k +: 3] <= spi_rx_data[2:0];
          r_to[k]           <= 1'b0;
          if (!spi_rx_data[16]) begin
            r_tc[14*k +: 14] <= spi_rx_data[31:18];
            r_jn[12*k +: 12] <= spi_rx_data[15:4];
            r_filt[k]        <= '0;
            r_fault[4*k+3]   <= 1'b0;
          end else begin
            r_filt[k]      <= (r_filt[k] == C_FILT) ? C_FILT : r_filt[k] + C_FILT_ONE;
            r_fault[4*k+3] <= (r_filt[k] >= C_FILT - C_FILT_ONE);
          end
        end
        if (w_to_set && r_ch == CH_BITS'(k)) begin
          r_to[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Bench for thermocouple_scanner: SPI slave driven procedurally, per-channel reference model of the captured state.
// Timing expectations: 2400-cycle startup, 800-cycle scan gap, 64-cycle handshake bound.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_thermocouple_scanner;

  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_en;
  logic              spi_not_busy;
  logic [31:0]       spi_rx_data;
  logic              spi_ena;
  logic [NCH-1:0]    spi_cs;
  logic [14*NCH-1:0] tc_temp_data;
  logic [12*NCH-1:0] junction_temp_data;
  logic [4*NCH-1:0]  fault_bits;
  logic [NCH-1:0]    timeout_flags;
  logic              sample_valid;
  logic [1:0]        sample_ch;

  always #5 clk = ~clk;

  thermocouple_scanner dut (
    .clk                (clk),
    .rst                (rst),
    .scan_en            (scan_en),
    .spi_not_busy       (spi_not_busy),
    .spi_rx_data        (spi_rx_data),
    .spi_ena            (spi_ena),
    .spi_cs             (spi_cs),
    .tc_temp_data       (tc_temp_data),
    .junction_temp_data (junction_temp_data),
    .fault_bits         (fault_bits),
    .timeout_flags      (timeout_flags),
    .sample_valid       (sample_valid),
    .sample_ch          (sample_ch)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: what each channel should currently report.
  logic [13:0] m_tc    [NCH];
  logic [11:0] m_jn    [NCH];
  logic [3:0]  m_fault [NCH];
  int          m_bad   [NCH];
  logic        m_to    [NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_tc[k] = '0; m_jn[k] = '0; m_fault[k] = '0; m_bad[k] = 0; m_to[k] = 1'b0;
    end
  endtask

  // A good frame refreshes temperatures; a faulty one only counts towards the filtered flag.
  task automatic model_capture(input int ch, input logic [31:0] fr);
    m_fault[ch][2:0] = fr[2:0];
    m_to[ch] = 1'b0;
    if (fr[16] == 1'b0) begin
      m_tc[ch] = fr[31:18];
      m_jn[ch] = fr[15:4];
      m_bad[ch] = 0;
      m_fault[ch][3] = 1'b0;
    end else begin
      if (m_bad[ch] < 2) m_bad[ch]++;
      m_fault[ch][3] = (m_bad[ch] >= 2);
    end
  endtask

  task automatic check_all(input string tag);
    logic [14*NCH-1:0] e_tc;
    logic [12*NCH-1:0] e_jn;
    logic [4*NCH-1:0]  e_f;
    logic [NCH-1:0]    e_to;
    for (int k = 0; k < NCH; k++) begin
      e_tc[14*k +: 14] = m_tc[k];
      e_jn[12*k +: 12] = m_jn[k];
      e_f[4*k +: 4]    = m_fault[k];
      e_to[k]          = m_to[k];
    end
    chk({tag, "_tc"}, tc_temp_data, e_tc);
    chk({tag, "_jn"}, junction_temp_data, e_jn);
    chk({tag, "_fault"}, fault_bits, e_f);
    chk({tag, "_to"}, timeout_flags, e_to);
  endtask

  function automatic logic [31:0] rnd_frame(input logic f);
    logic [31:0] fr;
    fr = $urandom;
    fr[16] = f;
    return fr;
  endfunction

  // Count falling edges until a request shows up, bounded.
  task automatic wait_ena(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spi_ena && n < 6000);
    chk("ena_seen", spi_ena, 1);
  endtask

  // mode 0: normal transfer, 1: master never goes busy, 2: master stays busy.
  task automatic xact(input int ch, input logic [31:0] fr, input int mode, input int exp_wait, input bit drop_en);
    int n;
    int b;
    wait_ena(n);
    if (exp_wait != 0) chk("wait_len", n, exp_wait);
    chk("cs_onehot", spi_cs, 64'(1) << ch);
    if (drop_en) scan_en = 1'b0;
    if (mode == 1) begin
      n = 0;
      while (spi_ena && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("req_to_len", n, 64);
      m_to[ch] = 1'b1;
      chk("req_to_cs", spi_cs, 0);
      check_all("req_to");
      return;
    end
    spi_not_busy = 1'b0;
    if (mode == 2) begin
      n = 0;
      while (!timeout_flags[ch] && n < 200) begin
        @(negedge clk);
        n++;
      end
      spi_not_busy = 1'b1;
      chk("busy_to_len", n, 65);
      chk("busy_to_ena", spi_ena, 0);
      m_to[ch] = 1'b1;
      check_all("busy_to");
      return;
    end
    b = $urandom_range(1, 6);
    repeat (b) begin
      @(negedge clk);
      chk("ena_busy", spi_ena, 0);
    end
    spi_rx_data  = fr;
    spi_not_busy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 20);
    chk("sample_valid", sample_valid, 1);
    chk("sample_ch", sample_ch, ch);
    @(negedge clk);
    chk("sv_pulse", sample_valid, 0);
    model_capture(ch, fr);
    check_all("cap");
  endtask

  task automatic check_reset_outputs();
    chk("rst_ena", spi_ena, 0);
    chk("rst_cs", spi_cs, 0);
    chk("rst_tc", tc_temp_data, 0);
    chk("rst_jn", junction_temp_data, 0);
    chk("rst_fault", fault_bits, 0);
    chk("rst_to", timeout_flags, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_sch", sample_ch, 0);
  endtask

  initial begin
    logic [13:0] tc1_saved;
    int n;
    int hi;
    rst = 1'b0;
    scan_en = 1'b1;
    spi_not_busy = 1'b1;
    spi_rx_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;

    // Scan 1: startup plus first period, then the documented frame on ch2.
    xact(0, rnd_frame(1'b0), 0, 3200, 1'b0);
    xact(1, rnd_frame(1'b0), 0, 0, 1'b0);
    xact(2, 32'h0190_1930, 0, 0, 1'b0);
    chk("tc2_fixed", tc_temp_data[41:28], 14'h0064);
    chk("jn2_fixed", junction_temp_data[35:24], 12'h193);
    chk("flt2_fixed", fault_bits[11:8], 4'h0);
    xact(3, rnd_frame(1'b0), 0, 0, 1'b0);

    // Scans 2-3: two faulty ch1 frames; scan 3 also has ch3 never going busy.
    tc1_saved = m_tc[1];
    xact(0, rnd_frame(1'b0), 0, 801, 1'b0);
    xact(1, rnd_frame(1'b1), 0, 0, 1'b0);
    chk("f7_after_1", fault_bits[7], 0);
    chk("tc1_hold_1", tc_temp_data[27:14], tc1_saved);
    xact(2, rnd_frame(1'b0), 0, 0, 1'b0);
    xact(3, rnd_frame(1'b0), 0, 0, 1'b0);
    xact(0, rnd_frame(1'b0), 0, 801, 1'b0);
    xact(1, rnd_frame(1'b1), 0, 0, 1'b0);
    chk("f7_after_2", fault_bits[7], 1);
    chk("tc1_hold_2", tc_temp_data[27:14], tc1_saved);
    xact(2, rnd_frame(1'b0), 0, 0, 1'b0);
    xact(3, 32'h0, 1, 0, 1'b0);
    chk("to3_set", timeout_flags[3], 1);

    // Scan 4: good ch1 clears the filter; scan_en drops mid-scan.
    xact(0, rnd_frame(1'b0), 0, 801, 1'b0);
    xact(1, rnd_frame(1'b0), 0, 0, 1'b1);
    chk("f7_cleared", fault_bits[7], 0);
    xact(2, rnd_frame(1'b0), 0, 0, 1'b0);
    xact(3, rnd_frame(1'b0), 0, 0, 1'b0);
    chk("to3_cleared", timeout_flags[3], 0);
    hi = 0;
    repeat (2000) begin
      @(negedge clk);
      if (spi_ena) hi++;
    end
    chk("parked_no_ena", hi, 0);
    scan_en = 1'b1;

    // Scan 5: ch0 stays busy too long, remaining channels random.
    xact(0, 32'h0, 2, 800, 1'b0);
    for (int c = 1; c < NCH; c++) xact(c, rnd_frame(1'($urandom_range(0, 1))), 0, 0, 1'b0);

    // Random scans.
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < NCH; c++) begin
        xact(c, rnd_frame(1'($urandom_range(0, 1))), 0, (c == 0) ? 801 : 0, 1'b0);
      end
    end

    // Reset while ch1 is busy.
    xact(0, rnd_frame(1'b0), 0, 801, 1'b0);
    wait_ena(n);
    chk("cs_ch1_pre_rst", spi_cs, 4'b0010);
    spi_not_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    spi_not_busy = 1'b1;
    model_reset();
    xact(0, rnd_frame(1'b0), 0, 3200, 1'b0);
    xact(1, rnd_frame(1'b1), 0, 0, 1'b0);
    chk("f7_post_rst", fault_bits[7], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
